// File: rtl/move_sequencer.sv
// Checkers move sequencer: picks a source and destination square with the cursor, validates
// the move against the external board RAM, and writes the updated squares back one per cycle.
module move_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cursor_loc,
    input  logic       sel,
    output logic [5:0] rd_addr,
    input  logic [2:0] rd_data,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [2:0] wr_data,
    output logic       turn,
    output logic [5:0] src_loc,
    output logic       src_valid,
    output logic       err,
    output logic [3:0] red_caps,
    output logic [3:0] blk_caps,
    output logic       game_over
);
    localparam logic [2:0] EMPTY    = 3'd0;
    localparam logic [2:0] RED_MAN  = 3'd1;
    localparam logic [2:0] RED_KING = 3'd2;
    localparam logic [2:0] BLK_MAN  = 3'd3;
    localparam logic [2:0] BLK_KING = 3'd4;
    localparam logic [3:0] MAX_CAPS = 4'd12;

    typedef enum logic [3:0] {
        SRC_WAIT, SRC_RD, SRC_CHK, DST_WAIT, DST_RD, DST_CHK, MID_RD,
        MID_CHK, WR_DST, WR_SRC, WR_MID, DONE, OVER
    } state_t;

    state_t     state;
    logic       sel_q, sel_qq, sel_ev;
    logic [5:0] dst_loc, mid_loc;
    logic [2:0] piece;
    logic       is_jump;
    logic [3:0] dx, dy, adx, ady;
    logic [2:0] mid_x, mid_y, dst_piece;
    logic       rd_red, rd_blk, own_src, opp_mid, backward, geom_ok;

    assign sel_ev = sel_q & ~sel_qq;

    // Zero-extend to 4 bits before subtracting so a 3-bit wrap can never fake a short move.
    assign dx  = {1'b0, dst_loc[5:3]} - {1'b0, src_loc[5:3]};
    assign dy  = {1'b0, dst_loc[2:0]} - {1'b0, src_loc[2:0]};
    assign adx = dx[3] ? (4'd0 - dx) : dx;
    assign ady = dy[3] ? (4'd0 - dy) : dy;
    assign mid_x = src_loc[5:3] + dx[3:1];
    assign mid_y = src_loc[2:0] + dy[3:1];

    assign rd_red   = (rd_data == RED_MAN) || (rd_data == RED_KING);
    assign rd_blk   = (rd_data == BLK_MAN) || (rd_data == BLK_KING);
    assign own_src  = turn ? rd_blk : rd_red;
    assign opp_mid  = turn ? rd_red : rd_blk;
    assign backward = ((piece == RED_MAN) && dy[3]) || ((piece == BLK_MAN) && !dy[3]);
    assign geom_ok  = (adx == ady) && ((adx == 4'd1) || (adx == 4'd2));

    assign dst_piece = ((piece == RED_MAN) && (dst_loc[2:0] == 3'd7)) ? RED_KING :
                       ((piece == BLK_MAN) && (dst_loc[2:0] == 3'd0)) ? BLK_KING : piece;

    // NOTE: every register here uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SRC_WAIT;
            sel_q     <= 1'b0;
            sel_qq    <= 1'b0;
            turn      <= 1'b0;
            src_loc   <= '0;
            src_valid <= 1'b0;
            dst_loc   <= '0;
            mid_loc   <= '0;
            piece     <= EMPTY;
            is_jump   <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            err       <= 1'b0;
            red_caps  <= '0;
            blk_caps  <= '0;
            game_over <= 1'b0;
        end else begin
            sel_q  <= sel;
            sel_qq <= sel_q;
            wr_en  <= 1'b0;
            err    <= 1'b0;
            case (state)
                SRC_WAIT: if (sel_ev) begin
                    src_loc <= cursor_loc;
                    rd_addr <= cursor_loc;
                    state   <= SRC_RD;
                end
                SRC_RD: state <= SRC_CHK;
                SRC_CHK: begin
                    piece <= rd_data;
                    if (own_src) begin
                        src_valid <= 1'b1;
                        state     <= DST_WAIT;
                    end else begin
                        err   <= 1'b1;
                        state <= SRC_WAIT;
                    end
                end
                DST_WAIT: if (sel_ev) begin
                    if (cursor_loc == src_loc) begin
                        src_valid <= 1'b0;
                        state     <= SRC_WAIT;
                    end else begin
                        dst_loc <= cursor_loc;
                        rd_addr <= cursor_loc;
                        state   <= DST_RD;
                    end
                end
                DST_RD: state <= DST_CHK;
                DST_CHK: begin
                    if ((rd_data != EMPTY) || !geom_ok || backward) begin
                        err   <= 1'b1;
                        state <= DST_WAIT;
                    end else if (adx == 4'd1) begin
                        is_jump <= 1'b0;
                        wr_en   <= 1'b1;
                        wr_addr <= dst_loc;
                        wr_data <= dst_piece;
                        state   <= WR_DST;
                    end else begin
                        is_jump <= 1'b1;
                        mid_loc <= {mid_x, mid_y};
                        rd_addr <= {mid_x, mid_y};
                        state   <= MID_RD;
                    end
                end
                MID_RD: state <= MID_CHK;
                MID_CHK: begin
                    if (opp_mid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= dst_loc;
                        wr_data <= dst_piece;
                        state   <= WR_DST;
                    end else begin
                        err   <= 1'b1;
                        state <= DST_WAIT;
                    end
                end
                // wr_en is raised on entry to each WR state, so it is high for that state's cycle only.
                WR_DST: begin
                    wr_en   <= 1'b1;
                    wr_addr <= src_loc;
                    wr_data <= EMPTY;
                    state   <= WR_SRC;
                end
                WR_SRC: begin
                    if (is_jump) begin
                        wr_en   <= 1'b1;
                        wr_addr <= mid_loc;
                        wr_data <= EMPTY;
                        state   <= WR_MID;
                    end else begin
                        state <= DONE;
                    end
                end
                WR_MID: begin
                    if (!turn) red_caps <= (red_caps == MAX_CAPS) ? MAX_CAPS : red_caps + 4'd1;
                    else       blk_caps <= (blk_caps == MAX_CAPS) ? MAX_CAPS : blk_caps + 4'd1;
                    state <= DONE;
                end
                DONE: begin
                    src_valid <= 1'b0;
                    turn      <= ~turn;
                    if ((red_caps == MAX_CAPS) || (blk_caps == MAX_CAPS)) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= SRC_WAIT;
                    end
                end
                OVER:    game_over <= 1'b1;
                default: state <= SRC_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: directed moves push expected writes/errors; a monitor
// pops and compares whenever the sequencer writes the board or flags an error.
module tb_move_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] cursor_loc = '0;
    logic       sel = 1'b0;
    logic [5:0] rd_addr;
    logic [2:0] rd_data = '0;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [2:0] wr_data;
    logic       turn;
    logic [5:0] src_loc;
    logic       src_valid;
    logic       err;
    logic [3:0] red_caps, blk_caps;
    logic       game_over;

    move_sequencer dut (
        .clk(clk), .rst(rst), .cursor_loc(cursor_loc), .sel(sel),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .turn(turn), .src_loc(src_loc), .src_valid(src_valid),
        .err(err), .red_caps(red_caps), .blk_caps(blk_caps), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_NONE, EV_WR, EV_ERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [5:0] addr;
        logic [2:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Board RAM model with a bench-side load port; one-cycle read latency.
    logic [2:0] mem [64];
    logic       ld_en = 1'b0, ld_clr = 1'b0;
    logic [5:0] ld_addr = '0;
    logic [2:0] ld_data = '0;

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (ld_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 3'd0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t      e;
        ev_kind_t act_kind;
        if (rst && (wr_en || err)) begin
            act_kind = wr_en ? EV_WR : EV_ERR;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{kind: EV_NONE, addr: 6'd0, data: 3'd0};
            check("event_kind", act_kind, e.kind);
            if (act_kind == EV_WR && e.kind == EV_WR) begin
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [5:0] sq(input int x, input int y);
        return {x[2:0], y[2:0]};
    endfunction

    task automatic exp_wr(input logic [5:0] addr, input logic [2:0] data);
        exp_q.push_back('{kind: EV_WR, addr: addr, data: data});
    endtask

    task automatic exp_err();
        exp_q.push_back('{kind: EV_ERR, addr: 6'd0, data: 3'd0});
    endtask

    task automatic board_clear();
        @(negedge clk); ld_clr = 1'b1;
        @(negedge clk); ld_clr = 1'b0;
    endtask

    task automatic put(input logic [5:0] addr, input logic [2:0] data);
        @(negedge clk); ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clk); ld_en = 1'b0;
    endtask

    task automatic press(input logic [5:0] loc, input int hold);
        @(negedge clk);
        cursor_loc = loc;
        sel = 1'b1;
        repeat (hold) @(negedge clk);
        sel = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_addr"},   rd_addr,   0);
        check({tag, "_wr_en"},     wr_en,     0);
        check({tag, "_wr_addr"},   wr_addr,   0);
        check({tag, "_wr_data"},   wr_data,   0);
        check({tag, "_turn"},      turn,      0);
        check({tag, "_src_loc"},   src_loc,   0);
        check({tag, "_src_valid"}, src_valid, 0);
        check({tag, "_err"},       err,       0);
        check({tag, "_red_caps"},  red_caps,  0);
        check({tag, "_blk_caps"},  blk_caps,  0);
        check({tag, "_game_over"}, game_over, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit found;
        board_clear();
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b1;

        // Simple red step (2,2)->(3,3).
        put(sq(2, 2), 3'd1);
        press(sq(2, 2), 2);
        check("t1_src_valid", src_valid, 1);
        check("t1_src_loc", src_loc, sq(2, 2));
        exp_wr(sq(3, 3), 3'd1);
        exp_wr(sq(2, 2), 3'd0);
        press(sq(3, 3), 2);
        check("t1_turn", turn, 1);
        check("t1_src_valid_clr", src_valid, 0);
        check("t1_pending", exp_q.size(), 0);

        // Red selects a black man: rejected, back in SRC_WAIT.
        do_reset();
        board_clear();
        put(sq(1, 5), 3'd3);
        exp_err();
        press(sq(1, 5), 2);
        check("t2_src_valid", src_valid, 0);
        check("t2_turn", turn, 0);
        put(sq(2, 2), 3'd1);
        press(sq(2, 2), 2);
        check("t2_reselect", src_valid, 1);
        check("t2_pending", exp_q.size(), 0);

        // Red jump captures black man on (3,3).
        do_reset();
        board_clear();
        put(sq(2, 2), 3'd1);
        put(sq(3, 3), 3'd3);
        press(sq(2, 2), 2);
        exp_wr(sq(4, 4), 3'd1);
        exp_wr(sq(2, 2), 3'd0);
        exp_wr(sq(3, 3), 3'd0);
        press(sq(4, 4), 2);
        check("t3_red_caps", red_caps, 1);
        check("t3_blk_caps", blk_caps, 0);
        check("t3_turn", turn, 1);
        check("t3_pending", exp_q.size(), 0);

        // Promotion, black backward rejection, black step, king moving backward.
        do_reset();
        board_clear();
        put(sq(3, 6), 3'd1);
        press(sq(3, 6), 2);
        exp_wr(sq(4, 7), 3'd2);
        exp_wr(sq(3, 6), 3'd0);
        press(sq(4, 7), 2);
        check("t4_turn_blk", turn, 1);
        put(sq(5, 2), 3'd3);
        press(sq(5, 2), 2);
        exp_err();
        press(sq(6, 3), 2);
        check("t4_src_kept", src_valid, 1);
        check("t4_src_loc", src_loc, sq(5, 2));
        exp_wr(sq(4, 1), 3'd3);
        exp_wr(sq(5, 2), 3'd0);
        press(sq(4, 1), 2);
        check("t4_turn_red", turn, 0);
        press(sq(4, 7), 2);
        exp_wr(sq(3, 6), 3'd2);
        exp_wr(sq(4, 7), 3'd0);
        press(sq(3, 6), 2);
        check("t4_king_turn", turn, 1);
        check("t4_pending", exp_q.size(), 0);

        // Cancel, held sel, and destination rejections with source retained.
        do_reset();
        board_clear();
        put(sq(2, 2), 3'd1);
        press(sq(2, 2), 2);
        press(sq(2, 2), 2);
        check("t5_cancel", src_valid, 0);
        check("t5_cancel_turn", turn, 0);
        press(sq(2, 2), 20);
        check("t5_held_one_event", src_valid, 1);
        exp_err(); press(sq(5, 5), 2);
        exp_err(); press(sq(2, 4), 2);
        exp_err(); press(sq(4, 4), 2);
        exp_err(); press(sq(1, 1), 2);
        put(sq(3, 3), 3'd1);
        exp_err(); press(sq(3, 3), 2);
        exp_err(); press(sq(4, 4), 2);
        check("t5_src_valid", src_valid, 1);
        check("t5_src_loc", src_loc, sq(2, 2));
        check("t5_turn", turn, 0);
        check("t5_pending", exp_q.size(), 0);

        // Eleven red captures interleaved with black steps, then the game-ending twelfth.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            board_clear();
            put(sq(2, 2), 3'd1);
            put(sq(3, 3), 3'd3);
            put(sq(7, 7), 3'd3);
            press(sq(2, 2), 2);
            exp_wr(sq(4, 4), 3'd1);
            exp_wr(sq(2, 2), 3'd0);
            exp_wr(sq(3, 3), 3'd0);
            press(sq(4, 4), 2);
            press(sq(7, 7), 2);
            exp_wr(sq(6, 6), 3'd3);
            exp_wr(sq(7, 7), 3'd0);
            press(sq(6, 6), 2);
        end
        check("t6_red_caps_11", red_caps, 11);
        check("t6_not_over", game_over, 0);
        check("t6_turn", turn, 0);
        board_clear();
        put(sq(2, 2), 3'd1);
        put(sq(3, 3), 3'd3);
        press(sq(2, 2), 2);
        exp_wr(sq(4, 4), 3'd1);
        exp_wr(sq(2, 2), 3'd0);
        exp_wr(sq(3, 3), 3'd0);
        press(sq(4, 4), 2);
        check("t6_red_caps_12", red_caps, 12);
        check("t6_game_over", game_over, 1);
        check("t6_turn_final", turn, 1);
        put(sq(7, 7), 3'd3);
        press(sq(7, 7), 2);
        check("t6_sel_ignored", src_valid, 0);
        check("t6_still_over", game_over, 1);
        check("t6_pending", exp_q.size(), 0);

        // Reset asserted during WR_SRC: source write must not land.
        do_reset();
        check_reset("rst_over");
        board_clear();
        put(sq(2, 2), 3'd1);
        press(sq(2, 2), 2);
        exp_wr(sq(3, 3), 3'd1);
        @(negedge clk);
        cursor_loc = sq(3, 3);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == sq(3, 3)) found = 1'b1;
        end
        check("t7_wr_dst_seen", found, 1);
        if (found) begin
            @(posedge clk);
            #1;
            check("t7_in_wr_src", wr_en && (wr_addr == sq(2, 2)), 1);
            rst = 1'b0;
            #1;
            check_reset("mid_wr");
            @(posedge clk);
            #1;
            check("t7_src_not_written", mem[sq(2, 2)], 1);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("t7_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 cursor_loc  in  6  cursor square {x[5:3], y[2:0]}.
REQ-004 sel  in  1  select button, active-high level; only its 0->1 edge acts.
REQ-005 rd_addr  out  6  board RAM read address, registered.
REQ-006 rd_data  in  3  board RAM read data, valid the cycle after rd_addr is presented; 0 empty, 1 red man, 2 red king, 3 black man, 4 black king.
REQ-007 wr_en / wr_addr / wr_data  out  1/6/3  board RAM write strobe, address and piece code, registered.
REQ-008 turn  out  1  side to move: 0 red, 1 black.
REQ-009 src_loc / src_valid  out  6/1  held source square, and its valid flag.
REQ-010 err  out  1  one-cycle pulse on a rejected selection.
REQ-011 red_caps / blk_caps  out  4/4  pieces captured by red / by black.
REQ-012 game_over  out  1  high once either capture count reaches 12.

Function
REQ-013 sel SHALL be edge-detected with a 1-cycle registered delay; a held sel SHALL produce exactly one event.
REQ-014 States: SRC_WAIT, SRC_RD, SRC_CHK, DST_WAIT, DST_RD, DST_CHK, MID_RD, MID_CHK, WR_DST, WR_SRC, WR_MID, DONE, OVER.
REQ-015 SRC_WAIT: on sel event, latch cursor_loc as src_loc, set rd_addr to it, go SRC_RD.
REQ-016 SRC_RD goes unconditionally to SRC_CHK; SRC_CHK samples rd_data.
REQ-017 SRC_CHK: piece owned by turn (red 1/2, black 3/4) -> src_valid=1, DST_WAIT; else err pulse, SRC_WAIT.
REQ-018 DST_WAIT: sel event on cursor_loc==src_loc -> cancel, src_valid=0, SRC_WAIT, no err; other square -> latch dst, rd_addr=dst, DST_RD.
REQ-019 Geometry uses 4-bit signed dx=dst.x-src.x and dy=dst.y-src.y; no 3-bit wrap is permitted.
REQ-020 Forward is dy>0 for red men and dy<0 for black men; kings may use either sign.
REQ-021 DST_CHK: dst not empty, |dx|!=|dy|, |dx| not 1 or 2, or a man moving backward -> err, DST_WAIT, src retained.
REQ-022 DST_CHK: |dx|=1 legal -> WR_DST; |dx|=2 -> rd_addr=mid=src+(dx/2,dy/2), MID_RD -> MID_CHK.
REQ-023 MID_CHK: mid holds an opponent piece -> WR_DST; else err, DST_WAIT.
REQ-024 WR_DST writes the moving piece to dst, promoting a man to a king (red man to 2 at y=7; black man to 4 at y=0).
REQ-025 WR_SRC writes 0 to src; WR_MID (jump only) writes 0 to mid and increments the mover's capture count.
REQ-026 wr_en SHALL be high exactly one cycle in each WR state and low otherwise.
REQ-027 DONE: src_valid=0, toggle turn; if any capture count equals 12, go OVER, else SRC_WAIT.
REQ-028 sel events in RD, CHK, WR and DONE states SHALL be discarded, not queued.
REQ-029 OVER: game_over=1; all sel events ignored until reset.
REQ-030 Capture counts saturate at 12; there are no multi-jumps and no forced captures.

Reset
REQ-031 While rst=0, and asynchronously on its assertion mid-operation: state SRC_WAIT, turn=0, src_valid=0, src_loc=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, err=0, caps=0, game_over=0, edge detector cleared; no write may complete after reset asserts.

Verification
REQ-032 Red man at (2,2), empty (3,3); select (2,2) then (3,3) -> writes (3,3)=1 then (2,2)=0, turn=1, err never high.
REQ-033 Red to move, select (1,5) holding 3 -> err one cycle, SRC_WAIT, src_valid=0, no wr_en.
REQ-034 Red man (2,2), black man (3,3), empty (4,4); select (2,2), (4,4) -> three writes (4,4)=1, (2,2)=0, (3,3)=0; red_caps=1.
REQ-035 Red man (3,6) moves to empty (4,7) -> wr_data=2 at (4,7); black man moving backward -> err, src retained.
REQ-036 Select (2,2), then (2,2) again -> src_valid=0, no err, no write; sel held 20 cycles -> exactly one event.
REQ-037 red_caps=11, legal red jump -> red_caps=12, game_over=1, later sel ignored; rst low mid-WR_SRC -> all outputs at reset values.
